// File: rtl/exa_crosb_vc_ingress_buf.sv
// Per-VC packet FIFOs with packet-granular write admission and arbiter-selected read head.
// Define EXA_VCBUF_STORE_FWD_EN for store-and-forward o_has_packet (complete packets only).
module exa_crosb_vc_ingress_buf #(
   parameter int VC_NUM        = 4,
   parameter int DWIDTH        = 128,
   parameter int TDEST_WIDTH   = 2,
   parameter int DEPTH         = 40,
   parameter int MAX_PKT_WORDS = 18,
   localparam int VC_W         = $clog2(VC_NUM),
   localparam int OCC_W        = $clog2(DEPTH + 1)
) (
   input  logic                          M_ACLK,
   input  logic                          M_ARESETN,
   input  logic                          i_wr_valid,
   output logic                          o_wr_ready,
   input  logic [DWIDTH-1:0]             i_wr_data,
   input  logic                          i_wr_last,
   input  logic [TDEST_WIDTH-1:0]        i_wr_tdest,
   input  logic [VC_W-1:0]               i_wr_vc,
   input  logic [VC_W-1:0]               i_rd_sel,
   input  logic                          i_rd_en,
   output logic                          o_rd_valid,
   output logic [DWIDTH-1:0]             o_rd_data,
   output logic                          o_rd_last,
   output logic [TDEST_WIDTH-1:0]        o_rd_tdest,
   output logic [VC_NUM-1:0]             o_has_packet,
   output logic [VC_NUM-1:0]             o_fifo_full,
   output logic [VC_NUM*TDEST_WIDTH-1:0] o_dests,
   output logic [VC_NUM*OCC_W-1:0]       o_occupancy
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WORD_W = TDEST_WIDTH + 1 + DWIDTH;
   // Largest occupancy that still leaves room for a maximum-size packet.
   localparam logic [OCC_W-1:0] ADMIT_LIM = OCC_W'(DEPTH - MAX_PKT_WORDS);

   typedef enum logic {ST_IDLE, ST_XFER} wr_state_t;

   wr_state_t         r_state;
   logic [VC_W-1:0]   r_cur_vc;
   logic [VC_W-1:0]   w_wr_vc;
   logic              w_wr_fire;
   logic              w_rd_fire;
   logic [VC_NUM-1:0] w_empty;
   logic [OCC_W-1:0]  w_occ  [VC_NUM];
   logic [WORD_W-1:0] w_head [VC_NUM];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_wr_vc    = (r_state == ST_IDLE) ? i_wr_vc : r_cur_vc;
   assign o_wr_ready = (r_state == ST_XFER) || (w_occ[i_wr_vc] <= ADMIT_LIM);
   assign w_wr_fire  = i_wr_valid & o_wr_ready;
   assign w_rd_fire  = i_rd_en & ~w_empty[i_rd_sel];

   assign o_rd_valid = ~w_empty[i_rd_sel];
   assign {o_rd_tdest, o_rd_last, o_rd_data} = w_head[i_rd_sel];

   always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
      if (!M_ARESETN) begin
         r_state  <= ST_IDLE;
         r_cur_vc <= '0;
      end else if (w_wr_fire) begin
         if (r_state == ST_IDLE) begin
            r_cur_vc <= i_wr_vc;
            if (!i_wr_last) r_state <= ST_XFER;
         end else if (i_wr_last) begin
            r_state <= ST_IDLE;
         end
      end
   end

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      logic [WORD_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0]  r_wptr;
      logic [PTR_W-1:0]  r_rptr;
      logic [OCC_W-1:0]  r_occ;
      logic              w_inc;
      logic              w_dec;

      assign w_inc = w_wr_fire && (w_wr_vc == VC_W'(v));
      assign w_dec = w_rd_fire && (i_rd_sel == VC_W'(v));

      always_ff @(posedge M_ACLK) begin
         if (w_inc) r_mem[r_wptr] <= {i_wr_tdest, i_wr_last, i_wr_data};
      end

      always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
         if (!M_ARESETN) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
         end else begin
            if (w_inc) r_wptr <= ptr_inc(r_wptr);
            if (w_dec) r_rptr <= ptr_inc(r_rptr);
            if (w_inc && !w_dec)      r_occ <= r_occ + OCC_W'(1);
            else if (!w_inc && w_dec) r_occ <= r_occ - OCC_W'(1);
         end
      end

      assign w_occ[v]    = r_occ;
      assign w_empty[v]  = (r_occ == '0);
      assign w_head[v]   = w_empty[v] ? '0 : r_mem[r_rptr];
      assign o_fifo_full[v] = (r_occ > ADMIT_LIM);
      assign o_dests[v*TDEST_WIDTH +: TDEST_WIDTH] = w_head[v][WORD_W-1 -: TDEST_WIDTH];
      assign o_occupancy[v*OCC_W +: OCC_W]         = r_occ;

`ifdef EXA_VCBUF_STORE_FWD_EN
      logic [OCC_W-1:0] r_pkts;
      logic             w_pkt_in;
      logic             w_pkt_out;

      assign w_pkt_in  = w_inc & i_wr_last;
      assign w_pkt_out = w_dec & w_head[v][DWIDTH];

      always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
         if (!M_ARESETN) begin
            r_pkts <= '0;
         end else if (w_pkt_in && !w_pkt_out) begin
            r_pkts <= r_pkts + OCC_W'(1);
         end else if (!w_pkt_in && w_pkt_out) begin
            r_pkts <= r_pkts - OCC_W'(1);
         end
      end

      assign o_has_packet[v] = (r_pkts != '0);
`else
      assign o_has_packet[v] = ~w_empty[v];
`endif
   end

endmodule

// File: tb/tb_exa_crosb_vc_ingress_buf.sv
// Self-checking bench for exa_crosb_vc_ingress_buf: vector table, corner sequences, random traffic vs queue model.
module tb_exa_crosb_vc_ingress_buf;
   localparam int VC_NUM = 4;
   localparam int DWIDTH = 128;
   localparam int TW     = 2;
   localparam int DEPTH  = 40;
   localparam int MAXP   = 18;
   localparam int VC_W   = 2;
   localparam int OCC_W  = 6;

   logic                     M_ACLK = 1'b0;
   logic                     M_ARESETN = 1'b0;
   logic                     i_wr_valid, o_wr_ready, i_wr_last, i_rd_en;
   logic [DWIDTH-1:0]        i_wr_data, o_rd_data;
   logic [TW-1:0]            i_wr_tdest, o_rd_tdest;
   logic [VC_W-1:0]          i_wr_vc, i_rd_sel;
   logic                     o_rd_valid, o_rd_last;
   logic [VC_NUM-1:0]        o_has_packet, o_fifo_full;
   logic [VC_NUM*TW-1:0]     o_dests;
   logic [VC_NUM*OCC_W-1:0]  o_occupancy;

   exa_crosb_vc_ingress_buf #(
      .VC_NUM(VC_NUM), .DWIDTH(DWIDTH), .TDEST_WIDTH(TW), .DEPTH(DEPTH), .MAX_PKT_WORDS(MAXP)
   ) dut (
      .M_ACLK(M_ACLK), .M_ARESETN(M_ARESETN),
      .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
      .i_wr_last(i_wr_last), .i_wr_tdest(i_wr_tdest), .i_wr_vc(i_wr_vc),
      .i_rd_sel(i_rd_sel), .i_rd_en(i_rd_en), .o_rd_valid(o_rd_valid),
      .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_rd_tdest(o_rd_tdest),
      .o_has_packet(o_has_packet), .o_fifo_full(o_fifo_full), .o_dests(o_dests),
      .o_occupancy(o_occupancy)
   );

   always #5 M_ACLK = ~M_ACLK;

   typedef struct packed {
      logic [TW-1:0]     td;
      logic              last;
      logic [DWIDTH-1:0] d;
   } flit_t;

   typedef struct {
      bit wv; int wvc; bit wl; int wtd; logic [31:0] wd; bit re; int rs;
      bit e_rdy; bit e_rv; bit e_rl; int e_rtd; logic [31:0] e_rd; int e_occ;
   } vec_t;

   flit_t mq [VC_NUM][$];
   bit    m_xfer;
   int    m_cur;
   int    m_len;
   int    total = 0;
   int    bad = 0;
   vec_t  tbl [12];

   task automatic chk(input string nm, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return m_xfer || ((DEPTH - mq[i_wr_vc].size()) >= MAXP);
   endfunction

   function automatic bit m_has(input int v);
`ifdef EXA_VCBUF_STORE_FWD_EN
      int n;
      n = 0;
      foreach (mq[v][k]) if (mq[v][k].last) n++;
      return n != 0;
`else
      return mq[v].size() != 0;
`endif
   endfunction

   function automatic int occ_of(input int v);
      return int'(o_occupancy[v*OCC_W +: OCC_W]);
   endfunction

   task automatic check_all(input string tag);
      flit_t h;
      flit_t hv;
      h = (mq[i_rd_sel].size() > 0) ? mq[i_rd_sel][0] : '0;
      chk({tag, ".rdy"}, DWIDTH'(o_wr_ready), DWIDTH'(m_ready()));
      chk({tag, ".rvalid"}, DWIDTH'(o_rd_valid), DWIDTH'(mq[i_rd_sel].size() > 0));
      chk({tag, ".rdata"}, o_rd_data, h.d);
      chk({tag, ".rlast"}, DWIDTH'(o_rd_last), DWIDTH'(h.last));
      chk({tag, ".rtdest"}, DWIDTH'(o_rd_tdest), DWIDTH'(h.td));
      for (int v = 0; v < VC_NUM; v++) begin
         hv = (mq[v].size() > 0) ? mq[v][0] : '0;
         chk($sformatf("%s.occ%0d", tag, v), DWIDTH'(occ_of(v)), DWIDTH'(mq[v].size()));
         chk($sformatf("%s.full%0d", tag, v), DWIDTH'(o_fifo_full[v]),
             DWIDTH'((DEPTH - mq[v].size()) < MAXP));
         chk($sformatf("%s.haspkt%0d", tag, v), DWIDTH'(o_has_packet[v]), DWIDTH'(m_has(v)));
         chk($sformatf("%s.dest%0d", tag, v), DWIDTH'(o_dests[v*TW +: TW]), DWIDTH'(hv.td));
      end
   endtask

   task automatic set_in(input bit wv, input int vc, input bit wl, input int td,
                         input logic [DWIDTH-1:0] d, input bit re, input int rs);
      i_wr_valid = wv;
      i_wr_vc    = VC_W'(vc);
      i_wr_last  = wl;
      i_wr_tdest = TW'(td);
      i_wr_data  = d;
      i_rd_en    = re;
      i_rd_sel   = VC_W'(rs);
      #1;
   endtask

   task automatic tick();
      bit    wf, rf, lst;
      int    tv, rs, wvc;
      flit_t f;
      wf  = i_wr_valid && m_ready();
      wvc = int'(i_wr_vc);
      tv  = m_xfer ? m_cur : wvc;
      rs  = int'(i_rd_sel);
      rf  = i_rd_en && (mq[rs].size() > 0);
      lst = i_wr_last;
      f   = {i_wr_tdest, i_wr_last, i_wr_data};
      @(posedge M_ACLK);
      if (rf) void'(mq[rs].pop_front());
      if (wf) begin
         mq[tv].push_back(f);
         if (!m_xfer) begin
            m_cur  = wvc;
            m_xfer = !lst;
         end else if (lst) begin
            m_xfer = 1'b0;
         end
         m_len = lst ? 0 : m_len + 1;
      end
      #1;
   endtask

   task automatic model_clear();
      for (int v = 0; v < VC_NUM; v++) mq[v].delete();
      m_xfer = 1'b0;
      m_cur  = 0;
      m_len  = 0;
   endtask

   task automatic do_reset();
      M_ARESETN = 1'b0;
      model_clear();
      set_in(0, 0, 0, 0, '0, 0, 0);
      check_all("rst");
      chk("rst.occ_all", DWIDTH'(o_occupancy), '0);
      chk("rst.dests_all", DWIDTH'(o_dests), '0);
      @(posedge M_ACLK);
      #1;
      M_ARESETN = 1'b1;
   endtask

   function automatic logic [DWIDTH-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send_pkt(input int vc, input int len, input int td);
      for (int k = 0; k < len; k++) begin
         set_in(1, vc, k == len - 1, td, rnd_data(), 0, vc);
         check_all("fill");
         tick();
      end
      set_in(0, 0, 0, 0, '0, 0, vc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      //            wv wvc wl wtd wd      re rs  rdy rv rl rtd rd      occ
      tbl[0]  = '{1, 2, 0, 1, 32'hA1, 0, 2,  1, 0, 0, 0, 32'h0,  0};
      tbl[1]  = '{1, 0, 0, 1, 32'hA2, 0, 2,  1, 1, 0, 1, 32'hA1, 1};
      tbl[2]  = '{1, 3, 1, 1, 32'hA3, 0, 2,  1, 1, 0, 1, 32'hA1, 2};
      tbl[3]  = '{0, 0, 0, 0, 32'h0,  0, 2,  1, 1, 0, 1, 32'hA1, 3};
      tbl[4]  = '{0, 0, 0, 0, 32'h0,  1, 2,  1, 1, 0, 1, 32'hA1, 3};
      tbl[5]  = '{0, 0, 0, 0, 32'h0,  1, 2,  1, 1, 0, 1, 32'hA2, 2};
      tbl[6]  = '{0, 0, 0, 0, 32'h0,  1, 2,  1, 1, 1, 1, 32'hA3, 1};
      tbl[7]  = '{0, 0, 0, 0, 32'h0,  1, 2,  1, 0, 0, 0, 32'h0,  0};
      tbl[8]  = '{0, 0, 0, 0, 32'h0,  0, 2,  1, 0, 0, 0, 32'h0,  0};
      tbl[9]  = '{1, 1, 1, 3, 32'hB1, 0, 1,  1, 0, 0, 0, 32'h0,  0};
      tbl[10] = '{0, 0, 0, 0, 32'h0,  1, 1,  1, 1, 1, 3, 32'hB1, 1};
      tbl[11] = '{0, 0, 0, 0, 32'h0,  0, 1,  1, 0, 0, 0, 32'h0,  0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].wv, tbl[i].wvc, tbl[i].wl, tbl[i].wtd, DWIDTH'(tbl[i].wd), tbl[i].re, tbl[i].rs);
         chk($sformatf("vec%0d.rdy", i), DWIDTH'(o_wr_ready), DWIDTH'(tbl[i].e_rdy));
         chk($sformatf("vec%0d.rvalid", i), DWIDTH'(o_rd_valid), DWIDTH'(tbl[i].e_rv));
         chk($sformatf("vec%0d.rlast", i), DWIDTH'(o_rd_last), DWIDTH'(tbl[i].e_rl));
         chk($sformatf("vec%0d.rtdest", i), DWIDTH'(o_rd_tdest), DWIDTH'(tbl[i].e_rtd));
         chk($sformatf("vec%0d.rdata", i), o_rd_data, DWIDTH'(tbl[i].e_rd));
         chk($sformatf("vec%0d.occ", i), DWIDTH'(occ_of(tbl[i].rs)), DWIDTH'(tbl[i].e_occ));
         if (i == 3) chk("vec3.dest2", DWIDTH'(o_dests[2*TW +: TW]), DWIDTH'(1));
         tick();
      end

      // Admission limit: 23 words in VC1 blocks a new VC1 header but not a VC0 one.
      do_reset();
      send_pkt(1, 18, 2);
      send_pkt(1, 1, 1);
      send_pkt(1, 4, 3);
      chk("adm.occ1", DWIDTH'(occ_of(1)), DWIDTH'(23));
      chk("adm.full1", DWIDTH'(o_fifo_full[1]), DWIDTH'(1));
      set_in(1, 1, 0, 2, rnd_data(), 0, 1);
      chk("adm.rdy_vc1", DWIDTH'(o_wr_ready), DWIDTH'(0));
      tick();
      set_in(1, 0, 1, 2, rnd_data(), 0, 0);
      chk("adm.rdy_vc0", DWIDTH'(o_wr_ready), DWIDTH'(1));
      tick();
      set_in(0, 0, 0, 0, '0, 0, 1);
      chk("adm.occ0", DWIDTH'(occ_of(0)), DWIDTH'(1));
      chk("adm.occ1_hold", DWIDTH'(occ_of(1)), DWIDTH'(23));
      check_all("adm");

      // Drain to 5 words (head is a single-flit packet), then enqueue+dequeue together.
      for (int k = 0; k < 18; k++) begin
         set_in(0, 0, 0, 0, '0, 1, 1);
         tick();
      end
      set_in(0, 0, 0, 0, '0, 0, 1);
      chk("simul.occ_before", DWIDTH'(occ_of(1)), DWIDTH'(5));
      chk("simul.head_last", DWIDTH'(o_rd_last), DWIDTH'(1));
      set_in(1, 1, 1, 0, rnd_data(), 1, 1);
      check_all("simul.pre");
      tick();
      set_in(0, 0, 0, 0, '0, 0, 1);
      chk("simul.occ_after", DWIDTH'(occ_of(1)), DWIDTH'(5));
      check_all("simul");

      // VC is fixed at the header; later i_wr_vc changes are ignored.
      do_reset();
      set_in(1, 0, 0, 1, rnd_data(), 0, 0);
      tick();
      set_in(1, 3, 0, 1, rnd_data(), 0, 0);
      tick();
      set_in(1, 3, 1, 1, rnd_data(), 0, 0);
      tick();
      set_in(0, 0, 0, 0, '0, 0, 0);
      chk("vcsw.occ0", DWIDTH'(occ_of(0)), DWIDTH'(3));
      chk("vcsw.occ3", DWIDTH'(occ_of(3)), DWIDTH'(0));
      check_all("vcsw");

      // Asynchronous reset mid-packet discards the partial packet.
      do_reset();
      set_in(1, 2, 0, 1, rnd_data(), 0, 2);
      tick();
      set_in(1, 2, 0, 1, rnd_data(), 0, 2);
      tick();
      set_in(0, 0, 0, 0, '0, 0, 2);
      chk("mrst.occ2_pre", DWIDTH'(occ_of(2)), DWIDTH'(2));
      M_ARESETN = 1'b0;
      model_clear();
      #1;
      chk("mrst.occ_all", DWIDTH'(o_occupancy), '0);
      check_all("mrst");
      @(posedge M_ACLK);
      #1;
      M_ARESETN = 1'b1;
      set_in(1, 1, 1, 3, rnd_data(), 0, 1);
      chk("mrst.rdy", DWIDTH'(o_wr_ready), DWIDTH'(1));
      tick();
      set_in(0, 0, 0, 0, '0, 0, 1);
      chk("mrst.occ1", DWIDTH'(occ_of(1)), DWIDTH'(1));
      chk("mrst.occ2", DWIDTH'(occ_of(2)), DWIDTH'(0));
      check_all("mrst.post");

      // Random traffic: write-heavy first to reach the admission limit, then read-heavy.
      do_reset();
      for (int i = 0; i < 2400; i++) begin
         int rp;
         bit wl;
         rp = (i < 1200) ? 2 : 12;
         wl = (m_len == MAXP - 1) || ($urandom_range(3) == 0);
         set_in($urandom_range(3) != 0, int'($urandom_range(VC_NUM - 1)), wl,
                int'($urandom_range((1 << TW) - 1)), rnd_data(),
                $urandom_range(15) < rp, int'($urandom_range(VC_NUM - 1)));
         check_all("rnd");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exa_crosb_vc_ingress_buf.md
EXA_CROSB_VC_INGRESS_BUF -- requirements
Module: exa_crosb_vc_ingress_buf

Interface
REQ-001 SHALL have parameter VC_NUM, default 4, meaning total prio*vc channel count (>=2).
REQ-002 SHALL have parameter DWIDTH, default 128, meaning flit data width.
REQ-003 SHALL have parameter TDEST_WIDTH, default 2, meaning output-port index width.
REQ-004 SHALL have parameter DEPTH, default 40, meaning words per VC FIFO (>= MAX_PKT_WORDS).
REQ-005 SHALL have parameter MAX_PKT_WORDS, default 18, meaning largest packet in flits (header+payload+footer).
REQ-006 SHALL have ports: M_ACLK  in  1  clock; the single clock.
REQ-007 M_ARESETN  in  1  reset; asynchronous, active-low.
REQ-008 i_wr_valid  in  1; o_wr_ready  out  1; write-side flit handshake.
REQ-009 i_wr_data  in  DWIDTH; i_wr_last  in  1; i_wr_tdest  in  TDEST_WIDTH; flit contents.
REQ-010 i_wr_vc  in  clog2(VC_NUM)  target VC, sampled only on a packet's first flit.
REQ-011 i_rd_sel  in  clog2(VC_NUM); i_rd_en  in  1; arbiter-selected VC and dequeue strobe.
REQ-012 o_rd_valid  out  1; o_rd_data  out  DWIDTH; o_rd_last  out  1; o_rd_tdest  out  TDEST_WIDTH; head of selected VC.
REQ-013 o_has_packet  out  VC_NUM; o_fifo_full  out  VC_NUM; o_dests  out  VC_NUM x TDEST_WIDTH (head tdest per VC).
REQ-014 o_occupancy  out  VC_NUM x clog2(DEPTH+1)  words stored per VC.

Function
REQ-015 Write FSM states IDLE, XFER; IDLE->XFER on accepted non-last first flit; XFER->IDLE on accepted last flit; single-flit packet stays IDLE.
REQ-016 In IDLE, o_wr_ready = 1 only if DEPTH - occupancy[i_wr_vc] >= MAX_PKT_WORDS (packet-granular admission, no mid-packet stall on space).
REQ-017 On accepted first flit, i_wr_vc latched into cur_vc; all XFER flits enqueue to cur_vc regardless of i_wr_vc.
REQ-018 In XFER, o_wr_ready = 1 unconditionally; admission in REQ-016 guarantees space.
REQ-019 Flit stored as {tdest,last,data} in FIFO of target VC; write latency: visible at head (o_rd_valid/o_dests) the cycle after acceptance.
REQ-020 o_rd_* combinationally reflect head of FIFO[i_rd_sel]; o_rd_valid = ~empty[i_rd_sel]; o_rd_last/o_rd_data/o_rd_tdest = 0 when empty.
REQ-021 Dequeue when i_rd_en & o_rd_valid; i_rd_en on empty VC SHALL be ignored with no state change.
REQ-022 occupancy[v] +1 on enqueue, -1 on dequeue, unchanged on simultaneous enqueue+dequeue same VC; never wraps.
REQ-023 Per-VC complete-packet counter pkts[v] (width clog2(DEPTH+1)): +1 on enqueue of last flit, -1 on dequeue of last flit, unchanged if both same cycle.
REQ-024 o_fifo_full[v] = (DEPTH - occupancy[v] < MAX_PKT_WORDS), registered-free (combinational from occupancy).
REQ-025 FIFO pointers wrap modulo DEPTH (DEPTH need not be power of 2).
REQ-026 o_dests[v] = head tdest of VC v, 0 when empty.

Reset
REQ-027 Assertion of M_ARESETN low SHALL immediately clear FSM to IDLE, cur_vc, pointers, occupancy and pkts to 0, including mid-packet; partial packets discarded.
REQ-028 During and after reset: o_wr_ready=1 (IDLE, empty), o_rd_valid=0, o_has_packet=0, o_fifo_full=0, o_occupancy=0, o_dests=0.

Configuration
REQ-029 Macro EXA_VCBUF_STORE_FWD_EN: when defined, o_has_packet[v] = (pkts[v] != 0) (store-and-forward); when undefined, o_has_packet[v] = ~empty[v] (cut-through), pkts logic may be omitted.

Verification
REQ-030 Reset, then 3-flit packet to VC2 (last on flit 3) -> occupancy[2]=3, o_dests[2]=tdest, o_has_packet[2]=1 cycle after flit 3 (STORE_FWD) or after flit 1 (cut-through).
REQ-031 Fill VC1 to 23 words (DEPTH 40, MAX 18) -> o_fifo_full[1]=1, new header to VC1 sees o_wr_ready=0; header to VC0 accepted.
REQ-032 Mid-packet i_wr_vc toggles 0->3 -> all flits land in VC0, occupancy[3]=0.
REQ-033 Simultaneous enqueue and dequeue on VC1 (occupancy 5) -> occupancy stays 5; pkts unchanged when both flits last.
REQ-034 i_rd_en with i_rd_sel on empty VC -> no pointer/occupancy change, o_rd_valid=0.
REQ-035 M_ARESETN low in XFER after 2 flits -> next cycle occupancy=0, FSM IDLE, next flit treated as header.
